gd_step_controller: RTL
=======================

Name: gd_step_controller

Overview:
- Iteration controller for the 1-D gradient-descent datapath, sitting directly downstream of the gradient/value step block.
- Issues a step request with the current x (Q24.8) and consumes the step's x_diff, value and overflow flag.
- Applies x <- x - x_diff with saturation, then decides whether to iterate again or stop (converged, iteration cap, overflow, timeout).
- Presents the final x, f(x) and iteration count to the host.

Parameters:
- MAX_ITER, 256, maximum step iterations per run (>=1).
- ITER_W, 16, width of the iteration counter (2^ITER_W > MAX_ITER).
- TOL, 32'h00000001, convergence threshold on |x_diff|, Q24.8 (1/256).
- TIMEOUT, 1024, maximum cycles spent waiting for one step_done.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request, sampled in IDLE only.
- x_init  in  32  signed Q24.8 starting point, captured with start.
- step_start  out  1  one-cycle launch pulse to the step block.
- step_x  out  32  signed Q24.8 current x presented to the step block; stable from launch until done.
- step_done  in  1  step result valid (level; may stay high several cycles).
- step_x_diff  in  32  signed Q24.8 learning-rate-scaled gradient.
- step_value  in  64  signed Q56.8 f(step_x).
- step_overflow  in  1  step arithmetic overflow.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse, run finished.
- status  out  2  0 = converged, 1 = max_iter reached, 2 = step overflow, 3 = step timeout; valid with done, held afterwards.
- x_out  out  32  signed Q24.8 final x, held.
- value_out  out  64  signed Q56.8 last accepted step_value, held.
- iter_count  out  ITER_W  number of accepted steps, held.

Behaviour:
- Reset values: step_start, busy and done are 0; status is 0; x_out, value_out, step_x and iter_count are 0; the FSM is in IDLE; the timeout counter and step_done_q are 0.
- Reset mid-run aborts immediately, with no done pulse.
- FSM states: IDLE, LAUNCH, WAIT, UPDATE, FINISH.
- IDLE:
  - start=1 loads x and step_x from x_init, clears iter_count, goes to LAUNCH and sets busy=1 on the next edge.
  - start while busy is ignored.
- LAUNCH:
  - step_start=1 for exactly this cycle.
  - Clears the timeout counter, then goes to WAIT.
- WAIT:
  - Accept on a rising edge of step_done (step_done & ~step_done_q; step_done_q registered every cycle).
  - A level still high from the previous step is not accepted.
  - On accept: latch x_diff, value and overflow, then go to UPDATE.
  - Otherwise increment the timeout counter. When it equals TIMEOUT-1 without an accept: status=3, go to FINISH.
- UPDATE (single cycle), evaluated in this priority:
  1. overflow latched: status=2, x is not updated, iter_count is not incremented, go to FINISH.
  2. Otherwise compute x_new = x - x_diff in 33-bit signed, saturated to 0x7FFFFFFF / 0x80000000. Set x=x_new, value_out=latched value, iter_count+1.
  3. If |x_diff| <= TOL: status=0, go to FINISH. |0x80000000| is treated as 0x7FFFFFFF.
  4. Else if iter_count+1 == MAX_ITER: status=1, go to FINISH.
  5. Else set step_x=x_new and go to LAUNCH.
- FINISH:
  - x_out=x; done=1 for one cycle; busy=0 on the next edge; go to IDLE.
  - start in the same cycle is ignored; start the cycle after is accepted.
- Latency per iteration: 3 cycles plus the step latency (LAUNCH, WAIT>=1, UPDATE).
- Timing from start to step_start: 1 cycle.
- Convergence and max_iter on the same update: converged wins.
- Overflow together with a small x_diff: overflow wins.

Decomposition:
- Shared package gd_pkg:
  - Q24.8 / Q56.8 width constants.
  - Status encodings ST_CONV, ST_MAXIT, ST_OVF, ST_TMO.
  - The FSM state enum.
  - Saturation limits Q_MAX=32'h7FFFFFFF and Q_MIN=32'h80000000.
- One sub-module: sat_sub32 (combinational 32-bit signed subtract with saturation plus abs-compare helper), reusable by other update stages.

Test Plan:
- Bench uses a behavioural step model with 5-cycle latency.
- Max-iteration run: x_init=0x00001000, model x_diff=0x00000100 constant, MAX_ITER=4 -> done with status=1, iter_count=4, x_out=0x00000C00, exactly 4 step_start pulses.
- Immediate convergence: x_init=0x00000A00, model x_diff=0x00000001, TOL=1 -> status=0, iter_count=1, x_out=0x000009FF, value_out equals the model value.
- Saturation: x_init=0x80000010, x_diff=0x00000100 -> x saturates to 0x80000000 (no wrap); with x_diff=0xFFFFFF00 and x_init=0x7FFFFFF0 -> 0x7FFFFFFF.
- Overflow: model asserts step_overflow on the 2nd step, x_diff=0x100 -> status=2, iter_count=1, x_out=x_init-0x100.
- Timeout and reset:
  - Model never raises step_done, TIMEOUT=16 -> done exactly 16 cycles after WAIT entry, status=3.
  - Separately, rst_n pulsed low mid-WAIT -> all outputs 0, no done.
- Handshake robustness:
  - step_done held high for 10 cycles across the UPDATE->LAUNCH boundary -> only one accept per step.
  - start pulsed while busy -> ignored; run result unchanged.

Source files
------------

// File: rtl/gd_pkg.sv
// Shared types and constants for the 1-D gradient-descent datapath.
package gd_pkg;

  localparam int unsigned Q_W    = 32;  // Q24.8
  localparam int unsigned VAL_W  = 64;  // Q56.8
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_CONV  = 2'd0;
  localparam logic [ST_W-1:0] ST_MAXIT = 2'd1;
  localparam logic [ST_W-1:0] ST_OVF   = 2'd2;
  localparam logic [ST_W-1:0] ST_TMO   = 2'd3;

  localparam logic [Q_W-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [Q_W-1:0] Q_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_UPDATE,
    S_FINISH
  } state_t;

  // Result captured from the step block on accept
  typedef struct packed {
    logic [Q_W-1:0]   x_diff;
    logic [VAL_W-1:0] value;
    logic             overflow;
  } step_rsp_t;

endpackage

// File: rtl/sat_sub32.sv
// Saturating signed a - b, plus a check of |b| against a tolerance.
module sat_sub32
  import gd_pkg::*;
(
  input  logic [Q_W-1:0] a,
  input  logic [Q_W-1:0] b,
  input  logic [Q_W-1:0] tol,
  output logic [Q_W-1:0] diff_c,
  output logic           b_small_c
);

  logic [Q_W:0]   wide;
  logic [Q_W-1:0] b_abs;

  always_comb begin
    wide = {a[Q_W-1], a} - {b[Q_W-1], b};
    if (wide[Q_W] != wide[Q_W-1]) begin
      diff_c = wide[Q_W] ? Q_MIN : Q_MAX;
    end else begin
      diff_c = wide[Q_W-1:0];
    end
    // Most negative value has no positive twin; clamp its magnitude
    if (b == Q_MIN) begin
      b_abs = Q_MAX;
    end else if (b[Q_W-1]) begin
      b_abs = Q_W'(-b);
    end else begin
      b_abs = b;
    end
    b_small_c = (b_abs <= tol);
  end

endmodule

// File: rtl/gd_step_controller.sv
// Iteration controller: launches steps, applies x <- x - x_diff, decides when to stop.
module gd_step_controller
  import gd_pkg::*;
#(
  parameter int unsigned MAX_ITER = 256,
  parameter int unsigned ITER_W   = 16,
  parameter logic [31:0] TOL      = 32'h0000_0001,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       x_init,
  output logic              step_start,
  output logic [31:0]       step_x,
  input  logic              step_done,
  input  logic [31:0]       step_x_diff,
  input  logic [63:0]       step_value,
  input  logic              step_overflow,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [31:0]       x_out,
  output logic [63:0]       value_out,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [Q_W-1:0]    x, x_nxt, step_x_nxt, x_out_nxt;
  logic [VAL_W-1:0]  value_out_nxt;
  logic [ITER_W-1:0] iter_nxt, iter_inc;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
  logic [ST_W-1:0]   status_nxt;
  logic              step_start_nxt, busy_nxt, done_nxt;
  logic              step_done_q, step_rise;
  step_rsp_t         rsp, rsp_nxt;
  logic [Q_W-1:0]    x_new;
  logic              diff_small;

  sat_sub32 u_sub (
    .a        (x),
    .b        (rsp.x_diff),
    .tol      (TOL),
    .diff_c   (x_new),
    .b_small_c(diff_small)
  );

  assign step_rise = step_done & ~step_done_q;
  assign iter_inc  = iter_count + ITER_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      x           <= '0;
      step_x      <= '0;
      x_out       <= '0;
      value_out   <= '0;
      iter_count  <= '0;
      tmo_cnt     <= '0;
      status      <= '0;
      step_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_done_q <= 1'b0;
      rsp         <= '0;
    end else begin
      state       <= state_nxt;
      x           <= x_nxt;
      step_x      <= step_x_nxt;
      x_out       <= x_out_nxt;
      value_out   <= value_out_nxt;
      iter_count  <= iter_nxt;
      tmo_cnt     <= tmo_nxt;
      status      <= status_nxt;
      step_start  <= step_start_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      step_done_q <= step_done;
      rsp         <= rsp_nxt;
    end
  end

  // Next-state and registered-output decode; done_nxt marks entry into FINISH
  always_comb begin
    state_nxt      = state;
    x_nxt          = x;
    step_x_nxt     = step_x;
    x_out_nxt      = x_out;
    value_out_nxt  = value_out;
    iter_nxt       = iter_count;
    tmo_nxt        = tmo_cnt;
    status_nxt     = status;
    step_start_nxt = 1'b0;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    rsp_nxt        = rsp;

    case (state)
      S_IDLE: begin
        if (start) begin
          x_nxt          = x_init;
          step_x_nxt     = x_init;
          iter_nxt       = '0;
          busy_nxt       = 1'b1;
          step_start_nxt = 1'b1;
          state_nxt      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmo_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (step_rise) begin
          rsp_nxt.x_diff   = step_x_diff;
          rsp_nxt.value    = step_value;
          rsp_nxt.overflow = step_overflow;
          state_nxt        = S_UPDATE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          status_nxt = ST_TMO;
          done_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      S_UPDATE: begin
        if (rsp.overflow) begin
          status_nxt = ST_OVF;
          done_nxt   = 1'b1;
        end else begin
          x_nxt         = x_new;
          value_out_nxt = rsp.value;
          iter_nxt      = iter_inc;
          if (diff_small) begin
            status_nxt = ST_CONV;
            done_nxt   = 1'b1;
          end else if (iter_inc == ITER_W'(MAX_ITER)) begin
            status_nxt = ST_MAXIT;
            done_nxt   = 1'b1;
          end else begin
            step_x_nxt     = x_new;
            step_start_nxt = 1'b1;
            state_nxt      = S_LAUNCH;
          end
        end
      end
      S_FINISH: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (done_nxt) begin
      state_nxt = S_FINISH;
      x_out_nxt = x_nxt;
    end
  end

endmodule
